// File: rtl/trajectory_integrator.sv
// Trajectory integrator: integrates CH signed channels per accepted sample
// vector, one channel per cycle, with rectangular or trapezoidal rule,
// saturating N-bit accumulators and sticky threshold-crossing flags.

// Single-channel update: forms the N+2 bit sum, clamps it to N bits and
// reports clamp and threshold-crossing events.
module trajectory_integrator_step #(
  parameter int N         = 64,
  parameter int DT_SHIFT  = 0,
  parameter int THRESHOLD = 30_000
)(
  input  logic         mode,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] x,
  input  logic [N-1:0] prev,
  output logic [N-1:0] acc_next,
  output logic         sat_hit,
  output logic         cross_hit
);
  localparam logic signed [N+1:0] MAXV = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] MINV = {3'b111, {(N-1){1'b0}}};
  localparam logic signed [N+1:0] THR  = (N+2)'(THRESHOLD);

  logic signed [N-1:0] rect;
  logic signed [N:0]   pair, pair_sh;
  logic signed [N+1:0] term, sum, clamped;

  // Step term per rule, widened sum, clamp and threshold compare
  always_comb begin
    rect    = $signed(x) >>> DT_SHIFT;
    pair    = {prev[N-1], prev} + {x[N-1], x};
    pair_sh = pair >>> (1 + DT_SHIFT);
    term    = mode ? {pair_sh[N], pair_sh} : {{2{rect[N-1]}}, rect};
    sum     = {{2{acc[N-1]}}, acc} + term;
    sat_hit = 1'b0;
    clamped = sum;
    if (sum > MAXV) begin
      clamped = MAXV;
      sat_hit = 1'b1;
    end else if (sum < MINV) begin
      clamped = MINV;
      sat_hit = 1'b1;
    end
    acc_next  = clamped[N-1:0];
    cross_hit = (clamped >= THR);
  end
endmodule

module trajectory_integrator #(
  parameter int N         = 64,
  parameter int CH        = 2,
  parameter int DT_SHIFT  = 0,
  parameter int THRESHOLD = 30_000
)(
  input  logic            clk,
  input  logic            resetb,
  input  logic            start,
  input  logic            clear,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*N-1:0] in_data,
  output logic            out_valid,
  output logic [CH*N-1:0] out_data,
  output logic [CH-1:0]   crossed,
  output logic [CH-1:0]   sat,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, WAIT, ACC, EMIT} state_t;
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 mode_q, mode_d;
  logic [CH-1:0][N-1:0] acc_q, acc_d, x_q, x_d, prev_q, prev_d;
  logic [CH-1:0]        crossed_q, crossed_d, sat_q, sat_d;

  logic [N-1:0] step_acc;
  logic         step_sat, step_cross;

  // One shared update unit; the FSM walks it across the channels
  trajectory_integrator_step #(
    .N(N), .DT_SHIFT(DT_SHIFT), .THRESHOLD(THRESHOLD)
  ) u_step (
    .mode     (mode_q),
    .acc      (acc_q[idx_q]),
    .x        (x_q[idx_q]),
    .prev     (prev_q[idx_q]),
    .acc_next (step_acc),
    .sat_hit  (step_sat),
    .cross_hit(step_cross)
  );

  // Next-state, datapath updates; clear overrides every state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    x_d       = x_q;
    prev_d    = prev_q;
    crossed_d = crossed_q;
    sat_d     = sat_q;
    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      prev_d    = '0;
      crossed_d = '0;
      sat_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          acc_d     = '0;
          prev_d    = '0;
          crossed_d = '0;
          sat_d     = '0;
          mode_d    = mode;
          state_d   = WAIT;
        end
        WAIT: if (in_valid) begin
          x_d     = in_data;
          idx_d   = '0;
          state_d = ACC;
        end
        ACC: begin
          acc_d[idx_q]  = step_acc;
          prev_d[idx_q] = x_q[idx_q];
          if (step_sat)   sat_d[idx_q]     = 1'b1;
          if (step_cross) crossed_d[idx_q] = 1'b1;
          if (idx_q == IW'(CH - 1)) state_d = EMIT;
          else                      idx_d   = idx_q + IW'(1);
        end
        EMIT: state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      x_q       <= '0;
      prev_q    <= '0;
      crossed_q <= '0;
      sat_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      prev_q    <= prev_d;
      crossed_q <= crossed_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = (state_q == WAIT);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign crossed   = crossed_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_trajectory_integrator.sv
// Scoreboard bench for trajectory_integrator (N=16, CH=3, THRESHOLD=100).
module tb_trajectory_integrator;
  localparam int N = 16, CH = 3;

  logic clk = 1'b0;
  logic resetb, start, clear, mode, in_valid;
  logic in_ready, out_valid, busy;
  logic [CH*N-1:0] in_data, out_data;
  logic [CH-1:0] crossed, sat;

  int checks = 0, failures = 0;

  typedef struct {
    logic [CH*N-1:0] data;
    logic [CH-1:0]   cr;
    logic [CH-1:0]   st;
  } exp_t;
  exp_t sb[$];

  trajectory_integrator #(.N(N), .CH(CH), .DT_SHIFT(0), .THRESHOLD(100)) dut (
    .clk(clk), .resetb(resetb), .start(start), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .crossed(crossed),
    .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input int a, input int b, input int c,
                               input logic [2:0] cr, input logic [2:0] st);
    exp_t e;
    e.data = {16'(c), 16'(b), 16'(a)};
    e.cr   = cr;
    e.st   = st;
    sb.push_back(e);
  endfunction

  // Monitor: every out_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid actual data=%0h required none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.data || crossed !== e.cr || sat !== e.st) begin
          failures++;
          $display("FAIL scoreboard actual data=%0h cr=%b sat=%b required data=%0h cr=%b sat=%b",
                   out_data, crossed, sat, e.data, e.cr, e.st);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int a, input int b, input int c);
    int n = 0;
    in_data  = {16'(c), 16'(b), 16'(a)};
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    tick(); tick();
  endtask

  task automatic restart(input logic m);
    clear = 1'b1; tick(); clear = 1'b0;
    mode = m; start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int acc_cyc[$];
    int ov_cyc[$];
    resetb = 1'b1; start = 1'b0; clear = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_crossed", 64'(crossed), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetb = 1'b0;
    tick();
    start = 1'b1; mode = 1'b0; tick(); start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_in_ready", 64'(in_ready), 64'd1);

    // Rectangular: ch0 += 10, ch1 += -3; mode flipped after start is ignored
    mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      push(10 * k, -3 * k, 0, (10 * k >= 100) ? 3'b001 : 3'b000, 3'b000);
      send(10, -3, 0);
    end
    drain();
    chk("rect_final_ch0", 64'(out_data[15:0]), 64'd120);
    chk("rect_final_ch1", 64'(out_data[31:16]), 64'(16'hffdc));

    // Trapezoidal: ch0 4,8,8 -> 2,8,16
    restart(1'b1);
    chk("clear_out_data", 64'(out_data), 64'd0);
    chk("clear_crossed", 64'(crossed), 64'd0);
    push(2, 0, 0, 3'b000, 3'b000);  send(4, 0, 0);
    push(8, 0, 0, 3'b000, 3'b000);  send(8, 0, 0);
    push(16, 0, 0, 3'b000, 3'b000); send(8, 0, 0);
    drain();

    // Saturation in both directions, sat sticky after leaving the rail
    restart(1'b0);
    push(30000, -30000, 0, 3'b001, 3'b000); send(30000, -30000, 0);
    push(32767, -32768, 0, 3'b001, 3'b011); send(30000, -30000, 0);
    push(32762, -32768, 0, 3'b001, 3'b011); send(-5, 0, 0);
    drain();

    // Latency: in_valid held, accept every 5 cycles, out_valid 3 after accept
    restart(1'b0);
    push(1, 1, 1, 3'b000, 3'b000);
    push(2, 2, 2, 3'b000, 3'b000);
    push(3, 3, 3, 3'b000, 3'b000);
    in_data = {16'd1, 16'd1, 16'd1};
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      logic pre;
      pre = in_ready;
      tick();
      if (pre && in_valid) acc_cyc.push_back(cyc);
      if (out_valid) begin
        ov_cyc.push_back(cyc);
        chk("ready_low_in_emit", 64'(in_ready), 64'd0);
      end
      if (acc_cyc.size() == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("lat_accepts", 64'(acc_cyc.size()), 64'd3);
    chk("lat_pulses", 64'(ov_cyc.size()), 64'd3);
    if (acc_cyc.size() == 3 && ov_cyc.size() == 3) begin
      chk("lat_spacing1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
      chk("lat_spacing2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd5);
      for (int i = 0; i < 3; i++)
        chk("lat_out_delay", 64'(ov_cyc[i] - acc_cyc[i]), 64'd3);
    end
    drain();

    // Clear during the 2nd ACC cycle: no pulse, everything zeroed
    send(200, 0, 0);
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("midclr_busy", 64'(busy), 64'd0);
    chk("midclr_out_data", 64'(out_data), 64'd0);
    chk("midclr_crossed", 64'(crossed), 64'd0);
    chk("midclr_sat", 64'(sat), 64'd0);
    repeat (6) tick();

    // Reset during ACC: partial update discarded, no pulse
    mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    send(500, 0, 0);
    tick();
    resetb = 1'b1; tick(); resetb = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_crossed", 64'(crossed), 64'd0);
    repeat (6) tick();

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trajectory_integrator.md
TRAJECTORY_INTEGRATOR -- requirements
Module: trajectory_integrator

Interface
REQ-001 SHALL have parameter N, default 64: signed fixed-point word width per channel (codebase scale, 10^-3 per LSB stage).
REQ-002 SHALL have parameter CH, default 2: number of integrated channels (valid range 1..16).
REQ-003 SHALL have parameter DT_SHIFT, default 0: step size dt = 2^-DT_SHIFT, applied by arithmetic right shift.
REQ-004 SHALL have parameter THRESHOLD, default 30_000: signed per-channel crossing level (30 km at codebase scale).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetb, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: begin run; clears the accumulators and latches mode.
REQ-008 SHALL have port clear, input, 1 bit: abort the run and return to idle.
REQ-009 SHALL have port mode, input, 1 bit: 0 = rectangular rule, 1 = trapezoidal rule.
REQ-010 SHALL have port in_valid, input, 1 bit: a sample vector is present.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-012 SHALL have port in_data, input, CH*N bits: signed samples, channel c in bits [c*N +: N].
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle pulse, all channels updated.
REQ-014 SHALL have port out_data, output, CH*N bits: registered accumulators, same packing as in_data.
REQ-015 SHALL have port crossed, output, CH bits: sticky flag, accumulator has reached THRESHOLD or more.
REQ-016 SHALL have port sat, output, CH bits: sticky flag, accumulator has saturated.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT, ACC and EMIT.
REQ-019 In IDLE, start SHALL zero all accumulators, prev-samples and flags, latch mode and move to WAIT on the same edge; start outside IDLE SHALL be ignored.
REQ-020 in_ready SHALL equal (state==WAIT); a sample SHALL be accepted on an edge with in_valid && in_ready, which latches in_data, sets the channel index to 0 and moves to ACC.
REQ-021 In ACC the block SHALL update one channel per cycle at index 0..CH-1, then move to EMIT, so EMIT is entered on the CH-th edge after acceptance.
REQ-022 out_valid SHALL be high exactly while in EMIT (one cycle); EMIT SHALL return to WAIT; out_valid SHALL have no backpressure.
REQ-023 Rectangular rule SHALL compute acc_next = acc + (x >>> DT_SHIFT).
REQ-024 Trapezoidal rule SHALL compute acc_next = acc + ((prev + x) >>> (1+DT_SHIFT)), with prev=0 for the first sample after start and prev <= x after each update.
REQ-025 Sums SHALL be formed at N+2 bits and clamped to [-2^(N-1), 2^(N-1)-1]; on a clamp the channel's sat bit SHALL be set and remain set until start, clear or reset.
REQ-026 After each channel update, if acc_next >= THRESHOLD (signed), that channel's crossed bit SHALL be set (sticky); a later fall below THRESHOLD SHALL NOT clear it.
REQ-027 Mode changes after start SHALL have no effect until the next start.
REQ-028 clear SHALL force IDLE on the next edge from any state, zero the accumulators and flags, and suppress a pending out_valid; it has priority over start and sample acceptance.
REQ-029 in_valid held during ACC or EMIT SHALL NOT cause a second acceptance; exactly one acceptance per WAIT visit.

Reset
REQ-030 resetb high at an edge SHALL force IDLE and drive in_ready=0, out_valid=0, out_data=0, crossed=0, sat=0, busy=0; it has priority over clear and start.
REQ-031 Reset asserted mid-ACC SHALL discard the partial update with no out_valid.

Verification
REQ-032 Reset: resetb=1 for 2 cycles -> all outputs 0, busy=0; then start -> busy=1, in_ready=1 next cycle.
REQ-033 Rectangular, CH=2: 12 samples of ch0=10, ch1=-3 -> ch0 reads 100 at the 10th out_valid with crossed[0]=1; final ch0=120, ch1=-36, crossed[1]=0.
REQ-034 Trapezoidal: ch0 samples 4, 8, 8 -> out_data ch0 = 2, 8, 16 at successive out_valid pulses.
REQ-035 Saturation, N=16: two rectangular samples of ch0=30000 -> ch0=32767, sat[0]=1; a further sample of -5 -> 32762, sat[0] stays 1.
REQ-036 Handshake/latency, CH=3: in_valid held high continuously -> out_valid exactly 3 cycles after each accept edge; one accept per 5 cycles; in_ready=0 during ACC/EMIT.
REQ-037 clear asserted at the 2nd ACC cycle -> IDLE next edge, out_data=0, flags 0, no out_valid pulse.
